exposure_timer: RTL and testbench
=================================

Name: exposure_timer

Overview:
- Upstream neighbour of the camera exposure-control FSM.
- Holds the user-adjustable exposure time. It changes in whole units via the exp_increase/exp_decrease buttons and saturates at EXP_MIN and EXP_MAX.
- On a start pulse from the control FSM, it times the exposure and returns a one-cycle ovf5 pulse when the exposure has elapsed.
- One exposure unit is CLK_PER_UNIT clock cycles.

Parameters:
- CLK_PER_UNIT, 4: clock cycles per exposure unit; must be >= 1.
- EXP_W, 5: width of the exposure-time register.
- EXP_MIN, 2: minimum exposure time in units; must be >= 1.
- EXP_MAX, 30: maximum exposure time in units; must be < 2**EXP_W.
- EXP_DEFAULT, 10: exposure time after reset; EXP_MIN <= EXP_DEFAULT <= EXP_MAX.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- exp_increase  input  1  level from button; a rising edge requests +1 unit.
- exp_decrease  input  1  level from button; a rising edge requests -1 unit.
- start  input  1  level from control FSM; sampled high in IDLE begins an exposure.
- ovf5  output  1  registered; high exactly one cycle when the exposure has elapsed.
- busy  output  1  registered; high while an exposure is being timed (COUNT or DONE).
- exp_time  output  EXP_W  current exposure-time register, in units.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, ovf5=0, busy=0, exp_time=EXP_DEFAULT. Prescaler, remaining count and both edge-detect history flops are 0.
- Reset has priority over every other event, including mid-COUNT and DONE. No ovf5 is produced for an aborted exposure.
- Edge detection: inc_edge = exp_increase & ~inc_prev; dec_edge is formed the same way. The history flops update every cycle in every state.
- Holding a button high gives exactly one step.
- Exposure-time update (IDLE only):
  - inc_edge & ~dec_edge & exp_time<EXP_MAX: exp_time+1.
  - dec_edge & ~inc_edge & exp_time>EXP_MIN: exp_time-1.
  - Both edges in the same cycle: no change.
  - At a limit: no change, with no wrap-around.
  - Edges occurring in COUNT or DONE are discarded, not queued.
- The new exp_time value is visible the cycle after the edge.
- State machine (3 states):
  - IDLE: start=1 at posedge -> COUNT. Load remaining=exp_time and prescaler=0; busy=1 from this edge. An exp_increase/exp_decrease edge in the same cycle as start is discarded.
  - COUNT: each posedge prescaler+1.
    - When prescaler==CLK_PER_UNIT-1, prescaler wraps to 0 and remaining decrements.
    - When the wrap occurs with remaining==1 -> DONE.
    - start is ignored.
  - DONE: ovf5=1 and busy=1 for this single cycle, then unconditionally -> IDLE. Entering IDLE sets ovf5=0 and busy=0. start is ignored.
- Latency: start sampled at edge E0 -> ovf5 high from edge E0+exp_time*CLK_PER_UNIT for one cycle; busy is high for exp_time*CLK_PER_UNIT+1 cycles.
- The exposure uses exp_time as latched at start; later button activity cannot alter it.
- start held continuously: the next exposure begins at the first posedge spent in IDLE. Back-to-back period = exp_time*CLK_PER_UNIT+2 cycles.
- CLK_PER_UNIT=1: remaining decrements every COUNT cycle; same timing formula.
- Remaining counter width = EXP_W. Prescaler width = clog2(CLK_PER_UNIT), minimum 1 bit.
- No other outputs; no combinational path from any input to any output.

Test Plan:
1. Reset for 2 cycles -> exp_time=10, ovf5=0, busy=0. Hold start=0 for 20 cycles -> no change.
2. Defaults, one-cycle start pulse at edge E0 -> busy high at E0; ovf5 high only in the cycle after edge E0+40; busy and ovf5 low from E0+41. Exactly one ovf5 pulse.
3. Saturation:
   - 25 separate exp_increase pulses from 10 -> exp_time=30.
   - Then 40 exp_decrease pulses -> 2.
   - exp_increase held high 10 cycles -> exactly +1 (2->3).
4. Simultaneous and blocked edges:
   - exp_increase and exp_decrease rising in the same cycle -> exp_time unchanged.
   - exp_increase pulses during busy -> exp_time unchanged after ovf5 and no late increment; the timed length is still the value latched at start.
5. exp_time=2 with start held high continuously -> ovf5 pulses 8 cycles after the first start sample, then periodically every 10 cycles; never two consecutive ovf5 cycles.
6. Reset asserted 20 cycles into a default exposure -> busy=0 and exp_time=10 next cycle; no ovf5 in the following 50 cycles with start=0.

Source files
------------

// File: rtl/exposure_timer.sv
// ---------------------------------------------------------------------------
// exposure_timer
//
// Holds the user-adjustable camera exposure time and times one exposure on
// request from the exposure-control FSM.
//
// The exposure time changes in whole units on rising edges of the
// exp_increase / exp_decrease buttons. It saturates at EXP_MIN and EXP_MAX and
// can only change while idle. A start sample in IDLE latches the current
// exposure time and counts it down, one unit every CLK_PER_UNIT cycles. When
// the exposure has elapsed, ovf5 pulses for exactly one cycle.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   synchronous, active-high reset
//   exp_increase  in   button level; a rising edge requests +1 unit
//   exp_decrease  in   button level; a rising edge requests -1 unit
//   start         in   level from control FSM; sampled high in IDLE starts
//   ovf5          out  registered one-cycle "exposure elapsed" pulse
//   busy          out  registered; high while an exposure is being timed
//   exp_time      out  current exposure time in units (EXP_W bits)
// ---------------------------------------------------------------------------
module exposure_timer #(
  parameter int CLK_PER_UNIT = 4,
  parameter int EXP_W        = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exp_increase,
  input  logic             exp_decrease,
  input  logic             start,
  output logic             ovf5,
  output logic             busy,
  output logic [EXP_W-1:0] exp_time
);

  // The prescaler is at least one bit wide, so CLK_PER_UNIT=1 still has a
  // legal register. In that case it sits at 0, which is also its last value,
  // so a unit elapses every cycle.
  localparam int PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;

  localparam logic [PW-1:0]    PRESC_LAST  = PW'(CLK_PER_UNIT - 1);
  localparam logic [EXP_W-1:0] EXP_MIN_V   = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] EXP_MAX_V   = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_DEF_V   = EXP_W'(EXP_DEFAULT);
  localparam logic [EXP_W-1:0] EXP_ONE     = EXP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [EXP_W-1:0] remaining_q, remaining_d;
  logic [EXP_W-1:0] exp_time_q, exp_time_d;
  logic             ovf5_q, ovf5_d;
  logic             busy_q, busy_d;
  logic             inc_prev_q, dec_prev_q;

  logic             inc_edge;
  logic             dec_edge;

  // Edges come from the previous button level. The history flops track the
  // buttons in every state, so a button that goes high during an exposure
  // does not produce a step later on.
  assign inc_edge = exp_increase & ~inc_prev_q;
  assign dec_edge = exp_decrease & ~dec_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      remaining_q <= '0;
      exp_time_q  <= EXP_DEF_V;
      ovf5_q      <= 1'b0;
      busy_q      <= 1'b0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      remaining_q <= remaining_d;
      exp_time_q  <= exp_time_d;
      ovf5_q      <= ovf5_d;
      busy_q      <= busy_d;
      inc_prev_q  <= exp_increase;
      dec_prev_q  <= exp_decrease;
    end
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    remaining_d = remaining_q;
    exp_time_d  = exp_time_q;
    ovf5_d      = 1'b0;   // ovf5 is set only on the edge that enters DONE
    busy_d      = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // start has priority, so a button edge in this cycle is dropped.
          state_d     = ST_COUNT;
          remaining_d = exp_time_q;
          presc_d     = '0;
          busy_d      = 1'b1;
        end else if (inc_edge && !dec_edge && (exp_time_q < EXP_MAX_V)) begin
          exp_time_d = exp_time_q + EXP_ONE;
        end else if (dec_edge && !inc_edge && (exp_time_q > EXP_MIN_V)) begin
          exp_time_d = exp_time_q - EXP_ONE;
        end
      end

      ST_COUNT: begin
        if (presc_q == PRESC_LAST) begin
          presc_d     = '0;
          remaining_d = remaining_q - EXP_ONE;
          if (remaining_q == EXP_ONE) begin
            state_d = ST_DONE;
            ovf5_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign ovf5     = ovf5_q;
  assign busy     = busy_q;
  assign exp_time = exp_time_q;

endmodule

// File: tb/tb_exposure_timer.sv
// ---------------------------------------------------------------------------
// tb_exposure_timer
//
// Scoreboard bench for exposure_timer. The stimulus side keeps an arithmetic
// reference model, indexed by posedge number:
//   - the exposure time is a saturating integer that moves on button edges;
//   - an exposure accepted at edge E0 is busy over edges E0 .. E0+N, with
//     N = exp_time*CLK_PER_UNIT;
//   - ovf5 appears after edge E0+N;
//   - the next start can be accepted from edge E0+N+2.
// For each accepted start, the expected ovf5 edge is pushed into a queue. A
// monitor runs on the falling edge, pops the queue and compares ovf5, busy
// and exp_time against the model.
// ---------------------------------------------------------------------------
module tb_exposure_timer;

  localparam int CPU     = 4;
  localparam int EXP_W   = 5;
  localparam int EXP_MIN = 2;
  localparam int EXP_MAX = 30;
  localparam int EXP_DEF = 10;

  logic             clk;
  logic             reset;
  logic             exp_increase;
  logic             exp_decrease;
  logic             start;
  logic             ovf5;
  logic             busy;
  logic [EXP_W-1:0] exp_time;

  exposure_timer #(
    .CLK_PER_UNIT (CPU),
    .EXP_W        (EXP_W),
    .EXP_MIN      (EXP_MIN),
    .EXP_MAX      (EXP_MAX),
    .EXP_DEFAULT  (EXP_DEF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .exp_increase (exp_increase),
    .exp_decrease (exp_decrease),
    .start        (start),
    .ovf5         (ovf5),
    .busy         (busy),
    .exp_time     (exp_time)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;

  // Reference model state, all expressed in posedge numbers.
  int   edge_cnt  = 0;
  int   m_exp     = EXP_DEF;
  logic m_iprev   = 1'b0;
  logic m_dprev   = 1'b0;
  int   next_free = 0;
  int   busy_lo   = 1;
  int   busy_hi   = 0;
  bit   checking  = 1'b0;
  int   ovf_q[$];

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endfunction

  // Called right at a posedge with the inputs that this edge samples.
  task automatic model_edge();
    logic ie, de;
    int   n;
    edge_cnt++;
    if (reset) begin
      m_exp     = EXP_DEF;
      m_iprev   = 1'b0;
      m_dprev   = 1'b0;
      next_free = edge_cnt + 1;
      busy_lo   = 1;
      busy_hi   = 0;
      ovf_q.delete();
      checking  = 1'b1;
    end else begin
      ie = exp_increase & ~m_iprev;
      de = exp_decrease & ~m_dprev;
      if (edge_cnt >= next_free) begin
        if (start) begin
          n         = m_exp * CPU;
          ovf_q.push_back(edge_cnt + n);
          busy_lo   = edge_cnt;
          busy_hi   = edge_cnt + n;
          next_free = edge_cnt + n + 2;
        end else if (ie && !de && m_exp < EXP_MAX) begin
          m_exp++;
        end else if (de && !ie && m_exp > EXP_MIN) begin
          m_exp--;
        end
      end
      m_iprev = exp_increase;
      m_dprev = exp_decrease;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic i, input logic d);
    reset        = r;
    start        = s;
    exp_increase = i;
    exp_decrease = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic inc_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic dec_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: compares the outputs after every edge, away from the posedge.
  always @(negedge clk) begin
    if (checking) begin
      automatic bit due = (ovf_q.size() > 0) && (ovf_q[0] == edge_cnt);
      if (ovf5 || due) begin
        chk("ovf5", int'(ovf5), int'(due));
        if (due) void'(ovf_q.pop_front());
      end
      chk("busy", int'(busy), int'(edge_cnt >= busy_lo && edge_cnt <= busy_hi));
      chk("exp_time", int'(exp_time), m_exp);
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; exp_increase = 1'b0; exp_decrease = 1'b0;

    // 1: reset, then idle with start low.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_exp_time", int'(exp_time), EXP_DEF);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf5", int'(ovf5), 0);
    idle(20);

    // 2: a single default exposure.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("start_busy", int'(busy), 1);
    idle(50);

    // 3: saturation in both directions, and a held button.
    inc_pulses(25);
    chk("sat_hi", int'(exp_time), EXP_MAX);
    dec_pulses(40);
    chk("sat_lo", int'(exp_time), EXP_MIN);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_inc", int'(exp_time), 3);

    // 4: simultaneous edges, then button edges during an exposure.
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("both_edges", int'(exp_time), 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);   // edge together with start is dropped
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    inc_pulses(5);
    idle(12);
    chk("busy_edges", int'(exp_time), 3);

    // 5: minimum exposure with start held continuously.
    dec_pulses(1);
    chk("to_min", int'(exp_time), EXP_MIN);
    for (int k = 0; k < 45; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(15);

    // 6: reset in the middle of a default exposure.
    inc_pulses(8);
    chk("back_def", int'(exp_time), EXP_DEF);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(19);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_exp", int'(exp_time), EXP_DEF);
    idle(50);

    // Random traffic, including occasional resets.
    for (int k = 0; k < 800; k++) begin
      cyc(($urandom_range(0, 149) == 0),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0));
    end
    idle(EXP_MAX * CPU + 10);
    chk("drain", ovf_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
